// File: rtl/mult_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier with HI/LO ownership for the MIPS core.
// Signed operands are converted to magnitudes, multiplied unsigned, and the sign is restored in FIN.
module mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start_mult,
  input  logic             Mult_sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Rd_hilo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Mult_busy,
  output logic             Mult_done,
  output logic             Mult_stall
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               done;

  // Two's-complement magnitude; the most negative value maps to 2**(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH-1:0] r;
    r = v;
    if (sgn && v[WIDTH-1]) r = ~v + 1'b1;
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start_mult) state_next = CALC;
      CALC:    if (cnt == LAST) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_mult) begin
            mcand  <= magnitude(A, Mult_sign);
            mplier <= magnitude(B, Mult_sign);
            neg    <= Mult_sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIN: begin
          {Hi, Lo} <= apply_sign(acc, neg);
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stall follows busy, so it drops in the done cycle when the new Hi/Lo are already readable.
  assign Mult_busy  = (state != IDLE);
  assign Mult_done  = done;
  assign Mult_stall = Mult_busy & Rd_hilo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: table of multiply vectors through a result scoreboard,
// plus hand-written sequences for reset, ignored restart, stall and back-to-back issue.
module tb_mult_sequencer;

  logic        clk;
  logic        Reset;
  logic        Start_mult;
  logic        Mult_sign;
  logic [31:0] A, B;
  logic        Rd_hilo;
  logic [31:0] Hi, Lo;
  logic        Mult_busy, Mult_done, Mult_stall;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[11];

  mult_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Start_mult(Start_mult),
    .Mult_sign (Mult_sign),
    .A         (A),
    .B         (B),
    .Rd_hilo   (Rd_hilo),
    .Hi        (Hi),
    .Lo        (Lo),
    .Mult_busy (Mult_busy),
    .Mult_done (Mult_done),
    .Mult_stall(Mult_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a start at the current negedge; returns at the first negedge after the start edge.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    Mult_sign  = sgn;
    A          = a;
    B          = b;
    Start_mult = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    Start_mult = 1'b0;
    A          = $urandom;
    B          = $urandom;
    Mult_sign  = 1'($urandom_range(0, 1));
  endtask

  // lat counts posedges after the start edge; Mult_done is expected at lat == 33.
  task automatic wait_done(input string name, input int lat0, output int lat, output int stalls);
    logic [63:0] held;
    logic        moved;
    held   = {Hi, Lo};
    moved  = 1'b0;
    lat    = lat0;
    stalls = 0;
    if (lat0 == 0) check({name, " busy"}, 64'(Mult_busy), 64'd1);
    while (!Mult_done && lat < 60) begin
      if ({Hi, Lo} !== held) moved = 1'b1;
      if (Mult_stall) stalls++;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " hold"}, 64'(moved), 64'd0);
    if (Mult_done) begin
      check({name, " busy_at_done"}, 64'(Mult_busy), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s scoreboard: got done with no expected result, expected none pending", name);
      end else begin
        check({name, " result"}, {Hi, Lo}, exp_q.pop_front());
      end
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (Mult_done) pulses++;
    end
  endtask

  initial begin
    int lat, stalls, pulses;
    logic [31:0] ra, rb;
    logic        rs;
    logic signed [63:0] sa, sb;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3]  = '{1'b0, 32'h00000006, 32'h00000007, 64'h00000000_0000002A};
    vecs[4]  = '{1'b0, 32'h00000000, 32'h12345678, 64'h00000000_00000000};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[6]  = '{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
    vecs[7]  = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};
    vecs[8]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2};
    vecs[9]  = '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE};

    Reset      = 1'b0;
    Start_mult = 1'b0;
    Mult_sign  = 1'b0;
    A          = '0;
    B          = '0;
    Rd_hilo    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset hilo", {Hi, Lo}, 64'd0);
    check("reset busy", 64'(Mult_busy), 64'd0);
    check("reset done", 64'(Mult_done), 64'd0);
    Reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].prod);
      wait_done($sformatf("vec%0d", i), 0, lat, stalls);
      @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'(i & 1);
      sa = rs ? 64'(signed'(ra)) : {32'd0, ra};
      sb = rs ? 64'(signed'(rb)) : {32'd0, rb};
      launch(rs, ra, rb, 64'(sa * sb));
      wait_done($sformatf("rand%0d", i), 0, lat, stalls);
      @(negedge clk);
    end

    // Restart request mid-CALC must be dropped.
    launch(1'b0, 32'd6, 32'd7, 64'd42);
    repeat (5) @(negedge clk);
    Start_mult = 1'b1;
    A          = 32'd2;
    B          = 32'd2;
    @(negedge clk);
    Start_mult = 1'b0;
    wait_done("ignore", 6, lat, stalls);
    count_done(40, pulses);
    check("ignore extra_done", 64'(pulses), 64'd0);

    // Stall window covers exactly the busy cycles.
    Rd_hilo = 1'b1;
    launch(1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    wait_done("stall", 0, lat, stalls);
    check("stall cycles", 64'(stalls), 64'd33);
    check("stall at_done", 64'(Mult_stall), 64'd0);
    @(negedge clk);
    check("stall idle", 64'(Mult_stall), 64'd0);
    Rd_hilo = 1'b0;
    @(negedge clk);

    // Back-to-back: second start issued in the done cycle.
    launch(1'b0, 32'd6, 32'd7, 64'd42);
    wait_done("b2b first", 0, lat, stalls);
    launch(1'b0, 32'd0, 32'h12345678, 64'd0);
    wait_done("b2b second", 0, lat, stalls);
    @(negedge clk);

    // Asynchronous reset at iteration 10 discards the operation and clears Hi/Lo.
    launch(1'b0, 32'd6, 32'd7, 64'd42);
    repeat (10) @(negedge clk);
    Reset = 1'b0;
    #1;
    check("midreset hilo", {Hi, Lo}, 64'd0);
    check("midreset busy", 64'(Mult_busy), 64'd0);
    exp_q.delete();
    @(negedge clk);
    Reset = 1'b1;
    count_done(40, pulses);
    check("midreset no_done", 64'(pulses), 64'd0);
    check("midreset hold", {Hi, Lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
